// File: rtl/encoder_pkg.sv
// Shared types for the request arbiter and the 8:3 encoder stage it feeds.
package encoder_pkg;
   localparam int N_REQ  = 8;
   localparam int CODE_W = 3;

   typedef logic [N_REQ-1:0]  onehot_t;
   typedef logic [CODE_W-1:0] code_t;
endpackage

// File: rtl/onehot_req_arbiter_rr_pick.sv
// Circular first-set finder: searches cand upward from last_ptr+1, wrapping to 0.
// Purely combinational; the double-width copy turns the wrap into a plain shift.
module rr_pick #(
   parameter int N_REQ = encoder_pkg::N_REQ,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] cand,
   input  logic [IDX_W-1:0] last_ptr,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   logic [IDX_W-1:0]   start;
   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   logic [IDX_W-1:0]   off;

   // N_REQ is a power of two, so the pointer wraps for free.
   assign start = last_ptr + IDX_W'(1);
   assign dbl   = {cand, cand};
   assign rot   = N_REQ'(dbl >> start);

   always_comb begin
      off = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) off = IDX_W'(k);
      end
   end

   assign found = |cand;
   assign idx   = start + off;

endmodule

// File: rtl/onehot_req_arbiter.sv
// Round-robin arbiter: pulsed requests -> registered one-hot grant, 1 cycle latency, one grant/cycle.
// Grant and pointer hold while gnt_valid & !gnt_ready; ARB_COALESCE_CNT_EN adds coalesce_cnt.
module onehot_req_arbiter #(
   parameter int N_REQ = encoder_pkg::N_REQ
`ifdef ARB_COALESCE_CNT_EN
   , parameter int CNT_W = 8
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             en,
   output logic [N_REQ-1:0] gnt_onehot,
   output logic             gnt_valid,
   input  logic             gnt_ready
`ifdef ARB_COALESCE_CNT_EN
   , output logic [CNT_W-1:0] coalesce_cnt
`endif
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [N_REQ-1:0] pending;
   logic [N_REQ-1:0] cand;
   logic [N_REQ-1:0] sel;
   logic [IDX_W-1:0] last_ptr;
   logic [IDX_W-1:0] idx;
   logic             found;
   logic             issue;

   assign cand = pending | req;

   rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
      .cand     (cand),
      .last_ptr (last_ptr),
      .idx      (idx),
      .found    (found)
   );

   assign sel   = N_REQ'(1) << idx;
   // A grant being accepted this cycle frees the slot, so the next one issues back-to-back.
   assign issue = en & found & (~gnt_valid | gnt_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         pending    <= '0;
         gnt_onehot <= '0;
         gnt_valid  <= 1'b0;
         last_ptr   <= '1;
      end else if (issue) begin
         gnt_onehot <= sel;
         gnt_valid  <= 1'b1;
         last_ptr   <= idx;
         pending    <= cand & ~sel;
      end else begin
         pending <= cand;
         if (gnt_valid & gnt_ready) begin
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
         end
      end
   end

`ifdef ARB_COALESCE_CNT_EN
   logic [CNT_W:0] cnt_sum;

   // Only bits already pending count as merged; a repeat of the held grant is fresh work.
   assign cnt_sum = {1'b0, coalesce_cnt} + (CNT_W+1)'($countones(req & pending));

   always_ff @(posedge clk) begin
      if (rst)                 coalesce_cnt <= '0;
      else if (cnt_sum[CNT_W]) coalesce_cnt <= '1;
      else                     coalesce_cnt <= cnt_sum[CNT_W-1:0];
   end
`endif

endmodule

// File: tb/tb_onehot_req_arbiter.sv
// Directed bench for onehot_req_arbiter; expected grants are queued as stimulus is driven.
module tb_onehot_req_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       en;
   logic [7:0] gnt_onehot;
   logic       gnt_valid;
   logic       gnt_ready;
`ifdef ARB_COALESCE_CNT_EN
   logic [7:0] coalesce_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic       v;
      logic [7:0] g;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   onehot_req_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .en         (en),
      .gnt_onehot (gnt_onehot),
      .gnt_valid  (gnt_valid),
      .gnt_ready  (gnt_ready)
`ifdef ARB_COALESCE_CNT_EN
      , .coalesce_cnt (coalesce_cnt)
`endif
   );

   // Drive one cycle of stimulus at the falling edge, queue the expected
   // grant for the following rising edge, and check it at the next falling edge.
   task automatic cyc(input logic r_rst, input logic [7:0] r_req, input logic r_en,
                      input logic r_rdy, input logic e_v, input logic [7:0] e_g,
                      input string tag);
      exp_t e;
      rst       = r_rst;
      req       = r_req;
      en        = r_en;
      gnt_ready = r_rdy;
      sb.push_back({e_v, e_g});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      assert (gnt_valid === e.v) else begin
         failures++;
         $error("FAIL %s valid: got %b want %b", tag, gnt_valid, e.v);
      end
      checks++;
      assert (gnt_onehot === e.g) else begin
         failures++;
         $error("FAIL %s onehot: got %h want %h", tag, gnt_onehot, e.g);
      end
   endtask

   initial begin
      logic [7:0] b;
      rst = 1'b1; req = 8'hFF; en = 1'b1; gnt_ready = 1'b1;
      @(negedge clk);

      // 1. reset with all requests high, then quiet
      cyc(1, 8'hFF, 1, 1, 0, 8'h00, "rst0");
      cyc(1, 8'hFF, 1, 1, 0, 8'h00, "rst1");
      cyc(0, 8'h00, 1, 1, 0, 8'h00, "post_rst");

      // 2. two simultaneous requests serialised back-to-back
      cyc(0, 8'h05, 1, 1, 1, 8'h01, "pair_a");
      cyc(0, 8'h00, 1, 1, 1, 8'h04, "pair_b");
      cyc(0, 8'h00, 1, 1, 0, 8'h00, "pair_idle");

      // 3. all lines held: strict rotation with wrap, then drain
      cyc(1, 8'h00, 1, 1, 0, 8'h00, "rst_ptr");
      b = 8'h01;
      for (int i = 0; i < 9; i++) begin
         cyc(0, 8'hFF, 1, 1, 1, b, "rot");
         b = {b[6:0], b[7]};
      end
      for (int i = 0; i < 7; i++) begin
         cyc(0, 8'h00, 1, 1, 1, b, "drain");
         b = {b[6:0], b[7]};
      end
      cyc(0, 8'h00, 1, 1, 0, 8'h00, "drain_idle");

      // 4. backpressure holds 0x10 while bit 0 pulses, then the pointer moves on
      cyc(0, 8'h10, 1, 0, 1, 8'h10, "bp_issue");
      for (int i = 0; i < 5; i++)
         cyc(0, (i % 2 == 0) ? 8'h01 : 8'h00, 1, 0, 1, 8'h10, "bp_hold");
      cyc(0, 8'h00, 1, 1, 1, 8'h01, "bp_next");
      cyc(0, 8'h00, 1, 1, 0, 8'h00, "bp_idle");

      // 5. en=0 freezes issue but still captures
      cyc(0, 8'h20, 0, 1, 0, 8'h00, "en0_pulse");
      for (int i = 0; i < 3; i++)
         cyc(0, 8'h00, 0, 1, 0, 8'h00, "en0_wait");
      cyc(0, 8'h00, 1, 1, 1, 8'h20, "en1_grant");
      cyc(0, 8'h00, 1, 1, 0, 8'h00, "en1_idle");

      // 6. repeated pulses of an already-pending line merge into one grant
      cyc(1, 8'h00, 1, 1, 0, 8'h00, "rst_co");
      cyc(0, 8'h01, 1, 0, 1, 8'h01, "co_hold");
      for (int i = 0; i < 4; i++)
         cyc(0, 8'h02, 1, 0, 1, 8'h01, "co_pulse");
`ifdef ARB_COALESCE_CNT_EN
      checks++;
      assert (coalesce_cnt === 8'd3) else begin
         failures++;
         $error("FAIL co_cnt: got %0d want 3", coalesce_cnt);
      end
`endif
      cyc(0, 8'h00, 1, 1, 1, 8'h02, "co_single");
      cyc(0, 8'h00, 1, 1, 0, 8'h00, "co_idle");

      // reset mid-operation discards pending work and the held grant
      cyc(0, 8'h0C, 1, 0, 1, 8'h04, "mid_issue");
      cyc(1, 8'h00, 1, 0, 0, 8'h00, "mid_rst");
      cyc(0, 8'h00, 1, 1, 0, 8'h00, "mid_after");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
